// File: rtl/fft_stream_io_pkg.sv
// Shared definitions for the FFT streaming adapter.
// Holds the controller state encoding, default frame geometry and the
// bank/address split of a sample index (bank = idx[1:0], addr = idx[ADDR_W+1:2]).
package fft_stream_io_pkg;

  localparam int N_PTS_DEF  = 2048;
  localparam int ADDR_W_DEF = 9;
  localparam int BANK_W     = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_UNLOAD
  } state_e;

endpackage

// File: rtl/fft_io_fifo.sv
// Synchronous output skid FIFO for result samples.
// Ports: clk/rst_n (sync active-low), push/din write side, pop/dout read side
// (dout shows the head entry), count/empty/full occupancy status.
// A push while full is only accepted if a pop frees a slot in the same cycle.
module fft_io_fifo
  import fft_stream_io_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/fft_stream_io.sv
// Host-side streaming adapter for the 4-bank FFT core.
// Ports: iCLK/iRESET (sync active-low); iS_* sample input stream;
// oM_* / iM_READY result output stream; oCORE_* write/read/start towards the
// core, iCORE_RE_* / iCORE_RDY back from it; oBUSY, oFRAME_DONE status.
//
// state     | meaning
// ST_IDLE   | waiting for the first sample of a frame (written on handshake)
// ST_LOAD   | scattering samples 1..N_PTS-1 into the banks
// ST_START  | one-cycle core start pulse
// ST_WAIT   | waiting for a rising edge of iCORE_RDY
// ST_UNLOAD | reading banks back, streaming results through the FIFO
module fft_stream_io
  import fft_stream_io_pkg::*;
#(
  parameter int N_PTS      = N_PTS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic [15:0]       iS_DATA,
  input  logic              iS_VALID,
  output logic              oS_READY,
  output logic [16:0]       oM_DATA,
  output logic              oM_VALID,
  input  logic              iM_READY,
  output logic              oM_LAST,
  output logic [15:0]       oCORE_DATA,
  output logic [ADDR_W-1:0] oCORE_ADDR_WR_0,
  output logic [ADDR_W-1:0] oCORE_ADDR_WR_1,
  output logic [ADDR_W-1:0] oCORE_ADDR_WR_2,
  output logic [ADDR_W-1:0] oCORE_ADDR_WR_3,
  output logic              oCORE_WE_0,
  output logic              oCORE_WE_1,
  output logic              oCORE_WE_2,
  output logic              oCORE_WE_3,
  output logic [ADDR_W-1:0] oCORE_ADDR_RD_0,
  output logic [ADDR_W-1:0] oCORE_ADDR_RD_1,
  output logic [ADDR_W-1:0] oCORE_ADDR_RD_2,
  output logic [ADDR_W-1:0] oCORE_ADDR_RD_3,
  output logic              oCORE_START,
  input  logic [16:0]       iCORE_RE_0,
  input  logic [16:0]       iCORE_RE_1,
  input  logic [16:0]       iCORE_RE_2,
  input  logic [16:0]       iCORE_RE_3,
  input  logic              iCORE_RDY,
  output logic              oBUSY,
  output logic              oFRAME_DONE
);

  localparam int IDX_W = ADDR_W + BANK_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PTS - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  n_q, n_d;
  logic [IDX_W-1:0]  k_q, k_d;
  logic              issue_done_q, issue_done_d;
  logic              rdy_prev_q;
  logic              frame_done_q, frame_done_d;
  // Read-tag pipe: {is_last, bank} per in-flight read.
  logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [2:0]        pipe_tag_q [RD_LAT];
  logic [2:0]        pipe_tag_d [RD_LAT];

  logic              s_ready, s_fire, issue, m_valid, pop, push;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty, fifo_full;
  logic [17:0]       fifo_din, fifo_dout;
  logic [16:0]       rd_data;
  int                inflight;

  // Outputs are forced quiet while reset is held, even before the first edge.
  assign s_ready  = iRESET && (state_q == ST_IDLE || state_q == ST_LOAD);
  assign s_fire   = s_ready && iS_VALID;
  assign m_valid  = iRESET && !fifo_empty;
  assign pop      = m_valid && iM_READY;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < RD_LAT; i++) begin
      if (pipe_vld_q[i]) inflight++;
    end
  end

  // Counting in-flight reads against free FIFO space keeps the FIFO from
  // overflowing no matter how the sink stalls.
  assign issue = (state_q == ST_UNLOAD) && !issue_done_q && !fifo_full &&
                 ((int'(fifo_count) + inflight) < FIFO_DEPTH);

  always_comb begin
    pipe_vld_d[0] = issue;
    pipe_tag_d[0] = {k_q == LAST_IDX, k_q[1:0]};
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_tag_d[i] = pipe_tag_q[i-1];
    end
  end

  always_comb begin
    rd_data = iCORE_RE_0;
    case (pipe_tag_q[RD_LAT-1][1:0])
      2'd0: rd_data = iCORE_RE_0;
      2'd1: rd_data = iCORE_RE_1;
      2'd2: rd_data = iCORE_RE_2;
      2'd3: rd_data = iCORE_RE_3;
    endcase
  end

  assign push     = pipe_vld_q[RD_LAT-1];
  assign fifo_din = {pipe_tag_q[RD_LAT-1][2], rd_data};

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    k_d          = k_q;
    issue_done_d = issue_done_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (s_fire) begin
          n_d     = n_q + 1'b1;
          state_d = (n_q == LAST_IDX) ? ST_START : ST_LOAD;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (iCORE_RDY && !rdy_prev_q) begin
          state_d      = ST_UNLOAD;
          k_d          = '0;
          issue_done_d = 1'b0;
        end
      end
      ST_UNLOAD: begin
        if (issue) begin
          k_d = k_q + 1'b1;
          if (k_q == LAST_IDX) issue_done_d = 1'b1;
        end
        if (pop && fifo_dout[17]) begin
          state_d      = ST_IDLE;
          n_d          = '0;
          k_d          = '0;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      k_q          <= '0;
      issue_done_q <= 1'b0;
      rdy_prev_q   <= 1'b0;
      frame_done_q <= 1'b0;
      pipe_vld_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_tag_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      k_q          <= k_d;
      issue_done_q <= issue_done_d;
      rdy_prev_q   <= iCORE_RDY;
      frame_done_q <= frame_done_d;
      pipe_vld_q   <= pipe_vld_d;
      for (int i = 0; i < RD_LAT; i++) pipe_tag_q[i] <= pipe_tag_d[i];
    end
  end

  fft_io_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (18)
  ) u_fifo (
    .clk   (iCLK),
    .rst_n (iRESET),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign oS_READY        = s_ready;
  assign oM_DATA         = fifo_dout[16:0];
  assign oM_VALID        = m_valid;
  assign oM_LAST         = m_valid && fifo_dout[17];
  assign oCORE_DATA      = s_fire ? iS_DATA : '0;
  assign oCORE_ADDR_WR_0 = iRESET ? n_q[IDX_W-1:2] : '0;
  assign oCORE_ADDR_WR_1 = iRESET ? n_q[IDX_W-1:2] : '0;
  assign oCORE_ADDR_WR_2 = iRESET ? n_q[IDX_W-1:2] : '0;
  assign oCORE_ADDR_WR_3 = iRESET ? n_q[IDX_W-1:2] : '0;
  assign oCORE_WE_0      = s_fire && (n_q[1:0] == 2'd0);
  assign oCORE_WE_1      = s_fire && (n_q[1:0] == 2'd1);
  assign oCORE_WE_2      = s_fire && (n_q[1:0] == 2'd2);
  assign oCORE_WE_3      = s_fire && (n_q[1:0] == 2'd3);
  assign oCORE_ADDR_RD_0 = iRESET ? k_q[IDX_W-1:2] : '0;
  assign oCORE_ADDR_RD_1 = iRESET ? k_q[IDX_W-1:2] : '0;
  assign oCORE_ADDR_RD_2 = iRESET ? k_q[IDX_W-1:2] : '0;
  assign oCORE_ADDR_RD_3 = iRESET ? k_q[IDX_W-1:2] : '0;
  assign oCORE_START     = iRESET && (state_q == ST_START);
  assign oBUSY           = iRESET && (state_q != ST_IDLE);
  assign oFRAME_DONE     = frame_done_q;

endmodule
